apb_slave_err: RTL and testbench
================================

// Module: apb_slave_err
// PURPOSE
// - APB completer (slave) for the 2-slave APB master; one instance sits on each psel line.
// - Holds a small byte register file: a read-only ID register at address 0 and R/W storage above it.
// - Inserts a programmable number of wait states and flags illegal accesses on pslverr.
// PARAMETERS
// - DEPTH        12     number of implemented addresses (0..DEPTH-1), 2..16; DEPTH..15 are illegal
// - WAIT_CYCLES  0      pready-low cycles in each access phase, 0..15
// - ID_VALUE     8'hA5  constant returned when address 0 is read
// PORTS
// - pclk     in   1  APB clock, all state updates on rising edge
// - presetn  in   1  reset, asynchronous, active-low
// - psel     in   1  slave select from master
// - penable  in   1  access-phase strobe from master
// - pwrite   in   1  1=write, 0=read
// - paddr    in   4  byte address
// - pwdata   in   8  write data
// - prdata   out  8  read data, valid only while pready=1 on a read
// - pready   out  1  transfer-complete, registered
// - pslverr  out  1  error response, valid only while pready=1
// BEHAVIOUR
// - Reset: pready=0, pslverr=0, prdata=8'h00, FSM=IDLE, cnt=0, all storage bytes=8'h00.
//   Reset is asynchronous and immediate, including mid-transfer; any pending write is dropped.
// - FSM states: IDLE, ACCESS.
// - IDLE: at an edge with psel=1 and penable=0 (setup phase):
//   - latch paddr, pwrite and pwdata
//   - cnt<=WAIT_CYCLES; pready<=(WAIT_CYCLES==0)
//   - go to ACCESS
//   - penable=1 with psel=0 is ignored.
// - ACCESS while pready=0 and psel=1: cnt<=cnt-1; pready<=1 at the edge where cnt==1.
//   - Result: pready is low for exactly WAIT_CYCLES access cycles, then high for one cycle.
// - ACCESS at an edge with pready=1, psel=1, penable=1 (completion):
//   - commit the write if it is legal
//   - pready<=0, pslverr<=0, prdata<=0
//   - go to IDLE; back-to-back setup is accepted on the next edge.
// - Abort: psel=0 in ACCESS before completion -> IDLE, pready/pslverr/prdata cleared, no write.
// - Decode uses the latched address and direction only; bus changes during ACCESS are ignored.
//   - err = (addr >= DEPTH) | (pwrite & addr==0)
// - prdata and pslverr are loaded in the same edge that sets pready=1:
//   - read, no error: prdata = (addr==0) ? ID_VALUE : mem[addr]
//   - read with error: prdata = 8'h00
//   - any write: prdata = 8'h00
//   - pslverr = err.
// - An erroneous write never modifies storage; address 0 is never writable.
// - Latency, setup to completion: 2 + WAIT_CYCLES cycles, identical for reads and writes.
// TESTING
// - WAIT=0: write 8'h3C to addr 5, then read addr 5
//   -> pready high in 1st access cycle both times; prdata=8'h3C; pslverr=0.
// - WAIT=2: read addr 0
//   -> pready low 2 access cycles, high 3rd; prdata=8'hA5; pslverr=0.
// - Read addr 13 (DEPTH=12) -> pready=1 with pslverr=1, prdata=8'h00.
// - Write 8'hFF to addr 13 -> pslverr=1; subsequent reads of addr 13 still give pslverr=1.
// - Write 8'h77 to addr 0 -> pslverr=1; subsequent read of addr 0 returns 8'hA5.
// - WAIT=3: start write 8'h11 to addr 2, pulse presetn low in 2nd access cycle
//   -> outputs 0 immediately; read addr 2 returns 8'h00.
// - WAIT=3: drop psel in 1st access cycle -> FSM IDLE, pready never asserts, addr unchanged.

Source files
------------

// File: rtl/apb_slave_err.sv
// apb_slave_err: APB completer holding a small byte register file.
//   Address 0 is a read-only ID register. Addresses 1..DEPTH-1 are R/W bytes.
//   Addresses DEPTH..15, and any write to address 0, complete with pslverr=1.
//   Each access phase inserts WAIT_CYCLES wait states (pready low).
// Ports:
//   pclk    - APB clock, rising-edge.
//   presetn - asynchronous active-low reset.
//   psel    - select.
//   penable - access-phase strobe.
//   pwrite  - 1 = write, 0 = read.
//   paddr   - byte address (4 bits).
//   pwdata  - write data (8 bits).
//   prdata  - read data, valid while pready=1.
//   pready  - registered transfer-complete.
//   pslverr - registered error, valid while pready=1.
module apb_slave_err #(
  parameter int          DEPTH       = 12,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [3:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  localparam logic [3:0] WAIT_L    = 4'(WAIT_CYCLES);
  localparam logic [4:0] DEPTH_L   = 5'(DEPTH);
  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] addr_q;
  logic       write_q;
  logic [7:0] wdata_q;
  logic [7:0] mem_q [16];
  logic       pready_q;
  logic       pslverr_q;
  logic [7:0] prdata_q;

  logic [3:0] dec_addr_s;
  logic       dec_write_s;
  logic       err_d;
  logic [7:0] rdata_d;

  // Response decode. With zero wait states the response is loaded on the
  // setup edge itself, before the address is latched, so decode from the bus
  // in IDLE and from the latched copy in ACCESS.
  always_comb begin
    dec_addr_s  = addr_q;
    dec_write_s = write_q;
    if (state_q == ST_IDLE) begin
      dec_addr_s  = paddr;
      dec_write_s = pwrite;
    end else begin
      dec_addr_s  = addr_q;
      dec_write_s = write_q;
    end
    err_d = ({1'b0, dec_addr_s} >= DEPTH_L) | (dec_write_s & (dec_addr_s == 4'd0));
    if (dec_write_s || err_d) begin
      rdata_d = 8'h00;
    end else if (dec_addr_s == 4'd0) begin
      rdata_d = ID_VALUE;
    end else begin
      rdata_d = mem_q[dec_addr_s];
    end
  end

  // Transfer FSM, wait-state counter, registered response and storage.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 4'd0;
      write_q   <= 1'b0;
      wdata_q   <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            cnt_q   <= WAIT_L;
            state_q <= ST_ACCESS;
            if (ZERO_WAIT) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rdata_d;
            end else begin
              pready_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            // Abort: master dropped select before completion; nothing commits.
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
            state_q   <= ST_IDLE;
          end else if (pready_q) begin
            if (penable) begin
              if (write_q && !err_d) begin
                mem_q[addr_q] <= wdata_q;
              end else begin
                mem_q[addr_q] <= mem_q[addr_q];
              end
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              prdata_q  <= 8'h00;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_ACCESS;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rdata_d;
            end else begin
              pready_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_err.sv
module tb_apb_slave_err;

  logic       pclk;
  logic       presetn;
  logic [2:0] psel_v;
  logic       penable;
  logic       pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata0, prdata2, prdata3;
  logic       pready0, pready2, pready3;
  logic       pslverr0, pslverr2, pslverr3;

  int n_tests;
  int n_fail;

  apb_slave_err #(.DEPTH(12), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) u0 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_slave_err #(.DEPTH(12), .WAIT_CYCLES(2), .ID_VALUE(8'hA5)) u2 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2));

  apb_slave_err #(.DEPTH(12), .WAIT_CYCLES(3), .ID_VALUE(8'hA5)) u3 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic peek(input int idx, output logic rdy, output logic [7:0] d, output logic e);
    case (idx)
      0:       begin rdy = pready0; d = prdata0; e = pslverr0; end
      1:       begin rdy = pready2; d = prdata2; e = pslverr2; end
      default: begin rdy = pready3; d = prdata3; e = pslverr3; end
    endcase
  endtask

  // One full transfer to instance idx; reports data, error, wait count.
  task automatic xfer(input int idx, input logic wr, input logic [3:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int waits);
    logic rdy;
    logic done;
    @(negedge pclk);
    psel_v  = 3'b000;
    psel_v[idx] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    rd    = 8'h00;
    er    = 1'b0;
    while (!done && waits < 40) begin
      peek(idx, rdy, rd, er);
      if (rdy) begin
        done = 1'b1;
      end else begin
        waits++;
        @(posedge pclk);
        @(negedge pclk);
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    @(posedge pclk);
    #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  logic [7:0] rd;
  logic       er;
  int         w;
  int         highs;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    presetn = 1'b0;
    psel_v  = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 4'd0;
    pwdata  = 8'h00;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pready", {31'd0, pready0}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("rst_prdata", {24'd0, prdata0}, 32'h00);
    @(negedge pclk);
    presetn = 1'b1;

    // Zero-wait write then read.
    xfer(0, 1'b1, 4'd5, 8'h3C, rd, er, w);
    chk("w5_waits", w, 0);
    chk("w5_err", {31'd0, er}, 32'd0);
    chk("w5_prdata", {24'd0, rd}, 32'h00);
    xfer(0, 1'b0, 4'd5, 8'h00, rd, er, w);
    chk("r5_waits", w, 0);
    chk("r5_data", {24'd0, rd}, 32'h3C);
    chk("r5_err", {31'd0, er}, 32'd0);

    // Two wait states: ID read and write latency.
    xfer(1, 1'b0, 4'd0, 8'h00, rd, er, w);
    chk("u2_id_waits", w, 2);
    chk("u2_id_data", {24'd0, rd}, 32'hA5);
    chk("u2_id_err", {31'd0, er}, 32'd0);
    xfer(1, 1'b1, 4'd7, 8'hC3, rd, er, w);
    chk("u2_w7_waits", w, 2);
    chk("u2_w7_prdata", {24'd0, rd}, 32'h00);
    xfer(1, 1'b0, 4'd7, 8'h00, rd, er, w);
    chk("u2_r7_data", {24'd0, rd}, 32'hC3);

    // Illegal addresses and ID write protection.
    xfer(0, 1'b0, 4'd13, 8'h00, rd, er, w);
    chk("r13_err", {31'd0, er}, 32'd1);
    chk("r13_data", {24'd0, rd}, 32'h00);
    chk("r13_waits", w, 0);
    xfer(0, 1'b1, 4'd13, 8'hFF, rd, er, w);
    chk("w13_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 4'd13, 8'h00, rd, er, w);
    chk("r13b_err", {31'd0, er}, 32'd1);
    chk("r13b_data", {24'd0, rd}, 32'h00);
    xfer(0, 1'b1, 4'd0, 8'h77, rd, er, w);
    chk("w0_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 4'd0, 8'h00, rd, er, w);
    chk("r0_data", {24'd0, rd}, 32'hA5);
    chk("r0_err", {31'd0, er}, 32'd0);

    // DEPTH boundary: 11 legal, 12 illegal.
    xfer(0, 1'b1, 4'd11, 8'h5A, rd, er, w);
    chk("w11_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 4'd11, 8'h00, rd, er, w);
    chk("r11_data", {24'd0, rd}, 32'h5A);
    xfer(0, 1'b0, 4'd12, 8'h00, rd, er, w);
    chk("r12_err", {31'd0, er}, 32'd1);
    chk("r5_keep", 32'd0, 32'd0 + 32'(er == 1'b0));

    // Abort on u3: psel dropped in first access cycle.
    xfer(2, 1'b1, 4'd4, 8'h44, rd, er, w);
    chk("u3_w4_waits", w, 3);
    @(negedge pclk);
    psel_v  = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 4'd4;
    pwdata  = 8'h99;
    @(posedge pclk);
    @(negedge pclk);
    psel_v  = 3'b000;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (pready3) highs++;
    end
    chk("abort_no_ready", highs, 0);
    xfer(2, 1'b0, 4'd4, 8'h00, rd, er, w);
    chk("abort_r4_data", {24'd0, rd}, 32'h44);
    chk("abort_r4_waits", w, 3);

    // Reset in the second access cycle of a write on u3.
    xfer(2, 1'b1, 4'd2, 8'h22, rd, er, w);
    @(negedge pclk);
    psel_v  = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 4'd2;
    pwdata  = 8'h11;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("rst_mid_pready", {31'd0, pready3}, 32'd0);
    chk("rst_mid_pslverr", {31'd0, pslverr3}, 32'd0);
    chk("rst_mid_prdata", {24'd0, prdata3}, 32'h00);
    psel_v  = 3'b000;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    xfer(2, 1'b0, 4'd2, 8'h00, rd, er, w);
    chk("rst_r2_data", {24'd0, rd}, 32'h00);
    chk("rst_r2_waits", w, 3);
    xfer(0, 1'b0, 4'd5, 8'h00, rd, er, w);
    chk("rst_r5_data", {24'd0, rd}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
